tone_synth: RTL and testbench

- Upstream sample source for the audio DAC path in the Musical Calculator.
- Accepts queued note requests (note code + duration) over a valid/ready handshake.
- Generates a square-wave tone at the equal-tempered note frequency and presents 16-bit signed samples on oAUD_outL/oAUD_outR.
- Paced by the codec LR clock, so the converter's audio_outL/audio_outR registers capture one new sample per frame.

---
 rtl/tone_pkg.sv | 50 +++++
 rtl/note_fifo.sv | 40 ++++
 rtl/tone_synth.sv | 149 ++++++++++++++
 tb/tb_tone_synth.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone synthesiser: note codes, tuning words, FSM states.
`timescale 1ns/1ps
package tone_pkg;

    localparam int PHASE_W = 24;
    localparam int CNT_W   = 17;

    localparam logic [3:0] NOTE_C4   = 4'd0;
    localparam logic [3:0] NOTE_CS4  = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_DS4  = 4'd3;
    localparam logic [3:0] NOTE_E4   = 4'd4;
    localparam logic [3:0] NOTE_F4   = 4'd5;
    localparam logic [3:0] NOTE_FS4  = 4'd6;
    localparam logic [3:0] NOTE_G4   = 4'd7;
    localparam logic [3:0] NOTE_GS4  = 4'd8;
    localparam logic [3:0] NOTE_A4   = 4'd9;
    localparam logic [3:0] NOTE_AS4  = 4'd10;
    localparam logic [3:0] NOTE_B4   = 4'd11;
    localparam logic [3:0] NOTE_C5   = 4'd12;
    localparam logic [3:0] NOTE_REST = 4'd15;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} tone_state_t;

    // Codes 13 and 14 are unassigned and sound as rests.
    function automatic logic is_rest(input logic [3:0] note);
        return (note == NOTE_REST) || (note > NOTE_C5);
    endfunction

    // round(f * 2^24 / 48000), equal temperament, A4 = 440 Hz
    function automatic logic [PHASE_W-1:0] note_tw(input logic [3:0] note);
        case (note)
            NOTE_C4:  return 24'd91445;
            NOTE_CS4: return 24'd96882;
            NOTE_D4:  return 24'd102643;
            NOTE_DS4: return 24'd108747;
            NOTE_E4:  return 24'd115213;
            NOTE_F4:  return 24'd122064;
            NOTE_FS4: return 24'd129322;
            NOTE_G4:  return 24'd137012;
            NOTE_GS4: return 24'd145160;
            NOTE_A4:  return 24'd153791;
            NOTE_AS4: return 24'd162936;
            NOTE_B4:  return 24'd172625;
            NOTE_C5:  return 24'd182890;
            default:  return 24'd0;
        endcase
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Small synchronous FIFO holding {note, dur} requests; depth must be a power of 2.
`timescale 1ns/1ps
module note_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/tone_synth.sv
// Square-wave note player paced by the codec LR clock; one sample per LRCK rise.
//   state | meaning
//   IDLE  | output silence, pop next request (DUR=0 requests are discarded)
//   PLAY  | emit +/-AMP from phase MSB, count down note samples
//   GAP   | emit GAP_SAMPLES of silence between notes
`timescale 1ns/1ps
module tone_synth
    import tone_pkg::*;
#(
    parameter logic [15:0] AMP              = 16'h2000,
    parameter int          SAMPLES_PER_UNIT = 480,
    parameter int          GAP_SAMPLES      = 96,
    parameter int          FIFO_DEPTH       = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iAUD_LRCK,
    input  logic        iNOTE_VALID,
    input  logic [3:0]  iNOTE,
    input  logic [7:0]  iDUR,
    output logic        oNOTE_READY,
    output logic [15:0] oAUD_outL,
    output logic [15:0] oAUD_outR,
    output logic        oSAMPLE_STB,
    output logic        oBUSY
);
    localparam logic [15:0]      AMP_NEG = ~AMP + 16'd1;
    localparam logic [CNT_W-1:0] SPU_C   = CNT_W'(SAMPLES_PER_UNIT);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic lrck_s1, lrck_s2, lrck_s3, tick;
    logic fifo_full, fifo_empty, pop;
    logic [11:0] head;
    logic [3:0]  head_note;
    logic [7:0]  head_dur;
    logic [CNT_W-1:0] start_cnt;

    tone_state_t      state_r, state_n;
    logic [PHASE_W-1:0] phase_r, phase_n, tw_r, tw_n;
    logic [CNT_W-1:0] cnt_r, cnt_n, gcnt_r, gcnt_n;
    logic             rest_r, rest_n, stb_r, stb_n;
    logic [15:0]      sample_r, sample_n;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            lrck_s3 <= 1'b0;
        end else begin
            lrck_s1 <= iAUD_LRCK;
            lrck_s2 <= lrck_s1;
            lrck_s3 <= lrck_s2;
        end
    end
    assign tick = lrck_s2 && !lrck_s3;

    note_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(12)) u_fifo (
        .clk     (iCLK),
        .rst     (iRST),
        .wr_en   (iNOTE_VALID),
        .wr_data ({iNOTE, iDUR}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_note = head[11:8];
    assign head_dur  = head[7:0];
    assign start_cnt = CNT_W'(head_dur) * SPU_C;

    always_comb begin
        state_n  = state_r;
        phase_n  = phase_r;
        tw_n     = tw_r;
        cnt_n    = cnt_r;
        gcnt_n   = gcnt_r;
        rest_n   = rest_r;
        sample_n = sample_r;
        stb_n    = 1'b0;
        pop      = 1'b0;
        if (tick) begin
            stb_n    = 1'b1;
            sample_n = '0;
            unique case (state_r)
                IDLE: if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_dur != 8'd0) begin
                        // First note sample goes out on the pop tick with phase = 0.
                        rest_n   = is_rest(head_note);
                        tw_n     = note_tw(head_note);
                        sample_n = is_rest(head_note) ? 16'd0 : AMP;
                        phase_n  = note_tw(head_note);
                        cnt_n    = start_cnt - CNT_ONE;
                        if (start_cnt == CNT_ONE) begin
                            state_n = GAP;
                            gcnt_n  = GAP_C;
                        end else begin
                            state_n = PLAY;
                        end
                    end
                end
                PLAY: begin
                    sample_n = rest_r ? 16'd0 : (phase_r[PHASE_W-1] ? AMP_NEG : AMP);
                    phase_n  = phase_r + tw_r;
                    cnt_n    = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_n = GAP;
                        gcnt_n  = GAP_C;
                    end
                end
                GAP: begin
                    gcnt_n = gcnt_r - CNT_ONE;
                    if (gcnt_r == CNT_ONE) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r  <= IDLE;
            phase_r  <= '0;
            tw_r     <= '0;
            cnt_r    <= '0;
            gcnt_r   <= '0;
            rest_r   <= 1'b0;
            sample_r <= '0;
            stb_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            phase_r  <= phase_n;
            tw_r     <= tw_n;
            cnt_r    <= cnt_n;
            gcnt_r   <= gcnt_n;
            rest_r   <= rest_n;
            sample_r <= sample_n;
            stb_r    <= stb_n;
        end
    end

    assign oNOTE_READY = !fifo_full;
    assign oAUD_outL   = sample_r;
    assign oAUD_outR   = sample_r;
    assign oSAMPLE_STB = stb_r;
    assign oBUSY       = (state_r != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_tone_synth.sv
// Scoreboard bench for tone_synth: accepted requests queue expected samples, a monitor checks each strobe.
`timescale 1ns/1ps
module tb_tone_synth;
    localparam int SPU       = 480;
    localparam int GAP       = 96;
    localparam int CLK_HALF  = 5;
    localparam int LRCK_HALF = 40;
    localparam logic [15:0] POS = 16'h2000;
    localparam logic [15:0] NEG = 16'hE000;

    logic        clk = 1'b0, rst = 1'b1, lrck = 1'b0, valid = 1'b0;
    logic [3:0]  note = 4'd0;
    logic [7:0]  dur = 8'd0;
    logic        ready, stb, busy;
    logic [15:0] outl, outr;

    int checks = 0, errors = 0;
    int cyc = 0, cyc_rise = 0, nz_seen = 0;
    logic [15:0] exp_q[$];

    tone_synth dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iAUD_LRCK   (lrck),
        .iNOTE_VALID (valid),
        .iNOTE       (note),
        .iDUR        (dur),
        .oNOTE_READY (ready),
        .oAUD_outL   (outl),
        .oAUD_outR   (outr),
        .oSAMPLE_STB (stb),
        .oBUSY       (busy)
    );

    always #CLK_HALF clk = ~clk;
    initial begin
        #3;
        forever #LRCK_HALF lrck = ~lrck;
    end
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge lrck) cyc_rise = cyc;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Equal-tempered tuning word from the frequency formula.
    function automatic longint model_tw(input int n);
        real f;
        f = 440.0 * (2.0 ** ((n - 9) / 12.0));
        return longint'($rtoi(f * 16777216.0 / 48000.0 + 0.5));
    endfunction

    task automatic model_push(input logic [3:0] n, input logic [7:0] d);
        longint tw, ph;
        bit rest;
        if (d == 8'd0) begin
            exp_q.push_back(16'h0000);   // the discard tick is silent
            return;
        end
        rest = (n > 4'd12);
        tw   = rest ? 0 : model_tw(int'(n));
        for (int k = 0; k < int'(d) * SPU; k++) begin
            ph = (longint'(k) * tw) % 64'sd16777216;
            if (rest)                exp_q.push_back(16'h0000);
            else if (ph >= 8388608)  exp_q.push_back(NEG);
            else                     exp_q.push_back(POS);
        end
        for (int k = 0; k < GAP; k++) exp_q.push_back(16'h0000);
    endtask

    always @(negedge clk) begin : monitor
        logic [15:0] e;
        int lat;
        if (!rst && stb) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
            check("sample_l", outl, e);
            check("sample_r", outr, e);
            check("busy", busy, exp_q.size() > 0);
            lat = cyc - cyc_rise;
            check("lrck_latency_ok", (lat == 3 || lat == 4), 1);
            if (outl != 16'h0) nz_seen++;
        end
    end

    task automatic sync_tick();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!stb && w < 100);
        check("tick_seen", stb, 1);
    endtask

    task automatic push_req(input logic [3:0] n, input logic [7:0] d);
        int w = 0;
        note  = n;
        dur   = d;
        valid = 1'b1;
        while (!ready && w < 10000) begin
            @(negedge clk);
            w++;
        end
        check("push_accept", ready, 1);
        if (ready) begin
            @(posedge clk);
            model_push(n, d);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((exp_q.size() != 0 || busy) && w < 30000) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_queue_len", exp_q.size(), 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_l", outl, 0);
        check("rst_out_r", outr, 0);
        check("rst_stb", stb, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 1);
        exp_q.delete();
        repeat (5) @(posedge clk);
        @(negedge lrck);
        #1 rst = 1'b0;
    endtask

    initial begin
        int base, w;
        do_reset();
        repeat (3) sync_tick();

        // single A4 note
        sync_tick();
        push_req(4'd9, 8'd1);
        wait_idle();

        // queue full: four accepted, fifth held until the first pop
        sync_tick();
        for (int i = 0; i < 4; i++) push_req(4'd0, 8'd1);
        check("ready_when_full", ready, 0);
        note = 4'd0; dur = 8'd1; valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!stb && w < 100);
        check("ready_after_pop", ready, 1);
        @(posedge clk);
        model_push(4'd0, 8'd1);
        @(negedge clk);
        valid = 1'b0;
        wait_idle();

        // rest and unassigned code
        sync_tick();
        push_req(4'd15, 8'd2);
        push_req(4'd13, 8'd1);
        wait_idle();

        // zero-duration request dropped, next note follows with no gap
        sync_tick();
        push_req(4'd9, 8'd0);
        push_req(4'd0, 8'd1);
        wait_idle();

        // randomized requests
        for (int i = 0; i < 5; i++) begin
            sync_tick();
            push_req(4'($urandom_range(15, 0)), 8'($urandom_range(1, 0)));
        end
        wait_idle();

        // reset during sample 200 of an A4 note with two more queued
        sync_tick();
        push_req(4'd9, 8'd1);
        push_req(4'd0, 8'd1);
        push_req(4'd4, 8'd1);
        base = nz_seen;
        w = 0;
        while (nz_seen < base + 201 && w < 10000) begin
            @(posedge clk);
            w++;
        end
        check("reached_sample_200", nz_seen - base, 201);
        #2;
        do_reset();
        repeat (60) sync_tick();
        check("post_reset_nonzero", nz_seen - base, 201);
        check("post_reset_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
